// File: rtl/ttl_bus_pkg.sv
// ttl_bus_pkg: shared widths and constants for the pulled-high bus capture FIFO.
package ttl_bus_pkg;
    localparam int BUS_WIDTH_DEFAULT = 8;
    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH-1:0] IDLE_VALUE();
        return '1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ttl_bus_fifo_mem.sv
// ttl_bus_fifo_mem: DEPTH x WIDTH storage, synchronous write, asynchronous read.
module ttl_bus_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ttl_bus_capture_fifo.sv
// ttl_bus_capture_fifo: samples the shared pulled-high bus into a FWFT FIFO tagged with float state.
// Optional TTL_BUS_FLOAT_CHECK_EN adds a sticky Bus_err for a floating bus not reading all ones.
module ttl_bus_capture_fifo
    import ttl_bus_pkg::*;
#(
    parameter int WIDTH      = BUS_WIDTH_DEFAULT,
    parameter int DEPTH      = 4,
    parameter int DELAY_RISE = 7,
    parameter int DELAY_FALL = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Load_bar,
    input  logic             Float_bar,
    input  logic [WIDTH-1:0] D,
    input  logic             Rd,
    input  logic             Clr_ovf,
    output logic [WIDTH-1:0] Q,
    output logic             Q_idle,
    output logic             Empty,
    output logic             Full,
    output logic             Overflow
`ifdef TTL_BUS_FLOAT_CHECK_EN
    ,
    output logic             Bus_err
`endif
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [MAX_WIDTH-1:0] IDLE_W = IDLE_VALUE();
    localparam logic [WIDTH-1:0] IDLE = IDLE_W[WIDTH-1:0];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, accept, empty, full;
    logic [WIDTH:0] head;

    assign empty  = count_q == '0;
    assign full   = count_q == CW'(DEPTH);
    assign push   = !Load_bar;
    assign pop    = Rd && !empty;
    // a pop frees the head slot, so a full FIFO still accepts a simultaneous push
    assign accept = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(accept);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(accept) - CW'(pop);
        ovf_d    = (push && full && !pop) ? 1'b1 : Clr_ovf ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    ttl_bus_fifo_mem #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH), .AW(PW)) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata ({!Float_bar, D}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

`ifdef TTL_BUS_FLOAT_CHECK_EN
    logic bus_err_q, bus_err_d;

    always_comb bus_err_d = (push && !Float_bar && D != IDLE) ? 1'b1 : Clr_ovf ? 1'b0 : bus_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus_err_q <= 1'b0;
        else        bus_err_q <= bus_err_d;
    end

    assign Bus_err = bus_err_q;
`endif

    assign Empty    = empty;
    assign Full     = full;
    assign Overflow = ovf_q;
    assign #(DELAY_RISE, DELAY_FALL) Q      = empty ? IDLE : head[WIDTH-1:0];
    assign #(DELAY_RISE, DELAY_FALL) Q_idle = empty ? 1'b0 : head[WIDTH];
endmodule

// File: tb/tb_ttl_bus_capture_fifo.sv
// tb_ttl_bus_capture_fifo: table-driven directed checks of the bus capture FIFO.
module tb_ttl_bus_capture_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Load_bar = 1'b1, Float_bar = 1'b1, Rd = 1'b0, Clr_ovf = 1'b0;
    logic [7:0] D = 8'h00;
    logic [7:0] Q;
    logic       Q_idle, Empty, Full, Overflow;
`ifdef TTL_BUS_FLOAT_CHECK_EN
    logic       Bus_err;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    ttl_bus_capture_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .Load_bar  (Load_bar),
        .Float_bar (Float_bar),
        .D         (D),
        .Rd        (Rd),
        .Clr_ovf   (Clr_ovf),
        .Q         (Q),
        .Q_idle    (Q_idle),
        .Empty     (Empty),
        .Full      (Full),
        .Overflow  (Overflow)
`ifdef TTL_BUS_FLOAT_CHECK_EN
        ,
        .Bus_err   (Bus_err)
`endif
    );

    typedef struct {
        logic       lb, fb, rd, clr;
        logic [7:0] d;
        logic [7:0] q;
        logic       qi, em, fu, ov, be;
    } vec_t;

    vec_t tbl [40];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [7:0] q, input logic qi, em, fu, ov);
        check("Q", idx, 32'(Q), 32'(q));
        check("Q_idle", idx, 32'(Q_idle), 32'(qi));
        check("Empty", idx, 32'(Empty), 32'(em));
        check("Full", idx, 32'(Full), 32'(fu));
        check("Overflow", idx, 32'(Overflow), 32'(ov));
    endtask

    function automatic vec_t v(input logic lb, fb, rd, clr, input logic [7:0] d,
                               input logic [7:0] q, input logic qi, em, fu, ov, be);
        vec_t r;
        r.lb = lb; r.fb = fb; r.rd = rd; r.clr = clr; r.d = d;
        r.q = q; r.qi = qi; r.em = em; r.fu = fu; r.ov = ov; r.be = be;
        return r;
    endfunction

    initial begin
        //            lb fb rd clr d       q      qi em fu ov be
        tbl[0]  = v(0, 1, 0, 0, 8'h12, 8'h12, 0, 0, 0, 0, 0);
        tbl[1]  = v(0, 1, 0, 0, 8'h34, 8'h12, 0, 0, 0, 0, 0);
        tbl[2]  = v(1, 1, 1, 0, 8'h00, 8'h34, 0, 0, 0, 0, 0);
        tbl[3]  = v(1, 1, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 0, 0);
        tbl[4]  = v(1, 1, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 0, 0);
        tbl[5]  = v(0, 1, 0, 0, 8'hA0, 8'hA0, 0, 0, 0, 0, 0);
        tbl[6]  = v(0, 1, 0, 0, 8'hA1, 8'hA0, 0, 0, 0, 0, 0);
        tbl[7]  = v(0, 1, 0, 0, 8'hA2, 8'hA0, 0, 0, 0, 0, 0);
        tbl[8]  = v(0, 1, 0, 0, 8'hA3, 8'hA0, 0, 0, 1, 0, 0);
        tbl[9]  = v(0, 1, 0, 0, 8'hA4, 8'hA0, 0, 0, 1, 1, 0);
        tbl[10] = v(1, 1, 1, 0, 8'h00, 8'hA1, 0, 0, 0, 1, 0);
        tbl[11] = v(1, 1, 1, 0, 8'h00, 8'hA2, 0, 0, 0, 1, 0);
        tbl[12] = v(1, 1, 1, 0, 8'h00, 8'hA3, 0, 0, 0, 1, 0);
        tbl[13] = v(1, 1, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 1, 0);
        tbl[14] = v(1, 1, 0, 1, 8'h00, 8'hFF, 0, 1, 0, 0, 0);
        tbl[15] = v(0, 1, 1, 0, 8'h77, 8'h77, 0, 0, 0, 0, 0);
        tbl[16] = v(1, 1, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 0, 0);
        tbl[17] = v(0, 1, 0, 0, 8'hB0, 8'hB0, 0, 0, 0, 0, 0);
        tbl[18] = v(0, 1, 0, 0, 8'hB1, 8'hB0, 0, 0, 0, 0, 0);
        tbl[19] = v(0, 1, 0, 0, 8'hB2, 8'hB0, 0, 0, 0, 0, 0);
        tbl[20] = v(0, 1, 0, 0, 8'hB3, 8'hB0, 0, 0, 1, 0, 0);
        tbl[21] = v(0, 1, 1, 0, 8'h55, 8'hB1, 0, 0, 1, 0, 0);
        tbl[22] = v(1, 1, 1, 0, 8'h00, 8'hB2, 0, 0, 0, 0, 0);
        tbl[23] = v(1, 1, 1, 0, 8'h00, 8'hB3, 0, 0, 0, 0, 0);
        tbl[24] = v(1, 1, 1, 0, 8'h00, 8'h55, 0, 0, 0, 0, 0);
        tbl[25] = v(1, 1, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 0, 0);
        tbl[26] = v(0, 1, 0, 0, 8'hC0, 8'hC0, 0, 0, 0, 0, 0);
        tbl[27] = v(0, 1, 0, 0, 8'hC1, 8'hC0, 0, 0, 0, 0, 0);
        tbl[28] = v(0, 1, 0, 0, 8'hC2, 8'hC0, 0, 0, 0, 0, 0);
        tbl[29] = v(0, 1, 0, 0, 8'hC3, 8'hC0, 0, 0, 1, 0, 0);
        tbl[30] = v(0, 1, 0, 1, 8'hC4, 8'hC0, 0, 0, 1, 1, 0);
        tbl[31] = v(1, 1, 0, 1, 8'h00, 8'hC0, 0, 0, 1, 0, 0);
        tbl[32] = v(1, 1, 1, 0, 8'h00, 8'hC1, 0, 0, 0, 0, 0);
        tbl[33] = v(1, 1, 1, 0, 8'h00, 8'hC2, 0, 0, 0, 0, 0);
        tbl[34] = v(1, 1, 1, 0, 8'h00, 8'hC3, 0, 0, 0, 0, 0);
        tbl[35] = v(1, 1, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 0, 0);
        tbl[36] = v(0, 0, 0, 0, 8'hFF, 8'hFF, 1, 0, 0, 0, 0);
        tbl[37] = v(1, 1, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 0, 0);
        tbl[38] = v(0, 0, 0, 0, 8'h7F, 8'h7F, 1, 0, 0, 0, 1);
        tbl[39] = v(1, 1, 1, 1, 8'h00, 8'hFF, 0, 1, 0, 0, 0);

        // asynchronous reset with no clock edge yet
        #1 reset = 1'b0;
        #8;
        chk_all(-1, 8'hFF, 0, 1, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #9;

        for (int i = 0; i < 40; i++) begin
            Load_bar = tbl[i].lb; Float_bar = tbl[i].fb; Rd = tbl[i].rd;
            Clr_ovf = tbl[i].clr; D = tbl[i].d;
            @(posedge clk);
            #9;
            chk_all(i, tbl[i].q, tbl[i].qi, tbl[i].em, tbl[i].fu, tbl[i].ov);
`ifdef TTL_BUS_FLOAT_CHECK_EN
            check("Bus_err", i, 32'(Bus_err), 32'(tbl[i].be));
`endif
        end

        // queue three entries, then pulse reset between clock edges
        Rd = 1'b0; Clr_ovf = 1'b0; Float_bar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Load_bar = 1'b0; D = 8'hE0 + 8'(i);
            @(posedge clk);
            #9;
        end
        Load_bar = 1'b1;
        chk_all(100, 8'hE0, 0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #8;
        chk_all(101, 8'hFF, 0, 1, 0, 0);
        #2 reset = 1'b1;
        Load_bar = 1'b0; D = 8'h9A;
        @(posedge clk);
        #9;
        chk_all(102, 8'h9A, 0, 0, 0, 0);
        Load_bar = 1'b1; Rd = 1'b1;
        @(posedge clk);
        #9;
        chk_all(103, 8'hFF, 0, 1, 0, 0);
        Rd = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ttl_bus_capture_fifo.md
Name: ttl_bus_capture_fifo

Overview:
Reader end of the shared pulled-high data bus. The bus is driven by the registered 3-state drivers, which present all ones when no driver is enabled. On each enabled clock edge this block samples the bus into a small first-word-fall-through FIFO. Each entry is tagged with whether the bus was floating at capture. Downstream logic (CPU datapath, debug/UART path) pops entries at its own pace.

Parameters:
WIDTH, 8, bus/data width in bits
DEPTH, 4, FIFO entries; power of two, ≥2
DELAY_RISE, 7, output rise delay (ns) on Q/Q_idle
DELAY_FALL, 7, output fall delay (ns) on Q/Q_idle

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low; clears all state
Load_bar  input  1  active-low capture strobe, sampled at posedge clk
Float_bar  input  1  active-low: no bus driver enabled this cycle (bus is pulled high)
D  input  WIDTH  shared bus value
Rd  input  1  active-high pop request, sampled at posedge clk
Clr_ovf  input  1  active-high synchronous clear of Overflow
Q  output  WIDTH  head entry data; all ones when empty
Q_idle  output  1  head entry captured while floating; 0 when empty
Empty  output  1  FIFO holds no entries
Full  output  1  FIFO holds DEPTH entries
Overflow  output  1  sticky: a capture was dropped

Behaviour:
- Reset (reset==0, asynchronous, independent of clk): wr_ptr=0, rd_ptr=0, count=0, Overflow=0. Outputs become Q=all ones, Q_idle=0, Empty=1, Full=0. Storage contents are don't-care.
- Reset mid-operation discards all queued entries immediately. The first capture after release lands in slot 0.
- push = (Load_bar==0). pop = (Rd==1) && !Empty.
- push && !Full: mem[wr_ptr] <= {Float_bar==0, D}; wr_ptr++ (wraps modulo DEPTH); count++.
- pop: rd_ptr++ (wraps modulo DEPTH); count--.
- push && pop, not full: both happen; count unchanged.
- push && pop when Full: pop frees the head slot and push is accepted into it; count stays DEPTH; Overflow unchanged.
- push && Full && !pop: capture dropped; Overflow <= 1. Queue contents are unchanged.
- push && pop when Empty: the pop is ignored and the push is accepted; count becomes 1.
- Rd when Empty (no push): ignored; no pointer movement, no error.
- Overflow clears only on reset or Clr_ovf==1 at posedge. If Clr_ovf and a new overflow event occur in the same cycle, the overflow wins and Overflow stays 1.
- Latency: an entry pushed at edge N appears on Q after edge N when the FIFO was empty (first-word fall-through; Q is combinational from mem[rd_ptr]).
- Empty = (count==0). Full = (count==DEPTH). Both are derived from the count register, not from pointer compare.
- Q = Empty ? all ones : mem[rd_ptr] data. Q_idle = Empty ? 0 : mem[rd_ptr] idle bit. Both outputs carry #(DELAY_RISE, DELAY_FALL) on the final assign.
- count width = clog2(DEPTH)+1; pointer width = clog2(DEPTH).

Optional Feature:
Macro: TTL_BUS_FLOAT_CHECK_EN
- Defined: adds output Bus_err (1 bit, reset 0, sticky, cleared by Clr_ovf with the same priority rule as Overflow). Bus_err is set at any posedge where push && Float_bar==0 && D != all ones, i.e. a floating bus not reading as pull-up (missing pull-up or contention). The check is made whether or not the capture is accepted.
- Undefined: no Bus_err port and no checking logic; all other behaviour is identical.

Decomposition:
- Package ttl_bus_pkg:
  - BUS_WIDTH_DEFAULT=8
  - IDLE_VALUE function returning {WIDTH{1'b1}}
  - ptr/count width localparam helpers via clog2
- Sub-module ttl_bus_fifo_mem: DEPTH x (WIDTH+1) storage with a synchronous write port and an asynchronous read port. The top level holds the pointers, count, flags and output muxing.

Test Plan:
- Reset then idle: reset=0 → Q=8'hFF, Q_idle=0, Empty=1, Full=0, Overflow=0 with no clock edges.
- Push 8'h12, 8'h34 with Float_bar=1 → Q=8'h12 after the first edge; Rd=1 for one cycle → Q=8'h34; second pop → Empty=1, Q=8'hFF.
- Push 5 bytes 8'hA0..8'hA4 without Rd → Full=1 after the 4th push, Overflow=1 after the 5th; popping 4 entries yields A0..A3 and 8'hA4 never appears; Clr_ovf=1 → Overflow=0.
- Full FIFO, Load_bar=0 and Rd=1 together with D=8'h55 → count stays 4, Overflow stays 0, 8'h55 emerges as the 4th subsequent pop.
- Float_bar=0, D=8'hFF capture → Q=8'hFF, Q_idle=1. With TTL_BUS_FLOAT_CHECK_EN: Float_bar=0, D=8'h7F → Bus_err=1.
- Three entries queued, then reset pulsed low mid-clock-cycle → Empty=1 and Q=8'hFF before the next edge; the next push lands and reads back correctly.
